// File: rtl/axonerve_kvs_cmd_issuer.sv
// rtl/axonerve_kvs_cmd_issuer.sv - host command front end for the Axonerve KVS kernel
// Issues one-cycle kernel strobes, tags in-order ACKs with their opcode, sequences INIT.
module axonerve_kvs_cmd_issuer #(
    parameter int OUTSTANDING_MAX = 16,
    parameter int RESP_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic         I_CLK,
    input  logic         I_RST,
    input  logic         I_S_VALID,
    output logic         O_S_READY,
    input  logic [2:0]   I_S_OP,
    input  logic [127:0] I_S_KEY,
    input  logic [127:0] I_S_MSK,
    input  logic [6:0]   I_S_PRI,
    input  logic [31:0]  I_S_VALUE,
    input  logic         I_K_READY,
    input  logic         I_K_WAIT,
    input  logic         I_K_CMD_FULL,
    output logic         O_K_CMD_INIT,
    output logic         O_K_CMD_VALID,
    output logic         O_K_CMD_ERASE,
    output logic         O_K_CMD_WRITE,
    output logic         O_K_CMD_SEARCH,
    output logic         O_K_CMD_UPDATE,
    output logic         O_K_CMD_READ,
    output logic [127:0] O_K_KEY_DAT,
    output logic [127:0] O_K_EKEY_MSK,
    output logic [6:0]   O_K_KEY_PRI,
    output logic [31:0]  O_K_KEY_VALUE,
    input  logic         I_K_ACK,
    input  logic         I_K_ENT_ERR,
    input  logic         I_K_SINGLE_HIT,
    input  logic         I_K_MULTI_HIT,
    input  logic [31:0]  I_K_KEY_VALUE,
    output logic         O_M_VALID,
    input  logic         I_M_READY,
    output logic [2:0]   O_M_OP,
    output logic [3:0]   O_M_STATUS,
    output logic [31:0]  O_M_VALUE,
    output logic [4:0]   O_OUTSTANDING,
    output logic         O_BUSY,
    output logic [1:0]   O_ERR
);
    localparam int TAW  = (OUTSTANDING_MAX > 1) ? $clog2(OUTSTANDING_MAX) : 1;
    localparam int RAW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int TOW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RSPW = 3 + 4 + 32;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_RUN,
        ST_DRAIN,
        ST_INIT_PULSE,
        ST_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     outstanding_q, outstanding_d;
    logic [TAW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [RAW-1:0] resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
    logic [RAW:0]   resp_cnt_q, resp_cnt_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic [1:0]     err_q, err_d;
    logic           k_valid_q, k_valid_d, k_search_q, k_search_d, k_write_q, k_write_d;
    logic           k_erase_q, k_erase_d, k_update_q, k_update_d, k_init_q, k_init_d;
    logic [127:0]   k_key_q, k_key_d, k_msk_q, k_msk_d;
    logic [6:0]     k_pri_q, k_pri_d;
    logic [31:0]    k_value_q, k_value_d;

    logic [2:0]      tag_mem [OUTSTANDING_MAX];
    logic [RSPW-1:0] resp_mem [RESP_DEPTH];

    logic            op_illegal, op_init, s_ready, accept, k_accept, ill_accept;
    logic            ack_ok, ack_spur, resp_wr, resp_rd, m_valid, tmo_hit;
    logic [RSPW-1:0] resp_wdata, resp_rdata;

    assign op_illegal = (I_S_OP > 3'd4);
    assign op_init    = (I_S_OP == 3'd4);

    // Illegal opcodes write the response buffer directly, so they yield to an ACK.
    assign s_ready = (state_q == ST_RUN) & I_K_READY & ~I_K_WAIT & ~I_K_CMD_FULL
                   & (int'(outstanding_q) < OUTSTANDING_MAX)
                   & ((int'(outstanding_q) + int'(resp_cnt_q)) < RESP_DEPTH)
                   & (~op_illegal | ~I_K_ACK);

    assign accept     = I_S_VALID & s_ready;
    assign k_accept   = accept & (I_S_OP < 3'd4);
    assign ill_accept = accept & op_illegal;
    assign ack_ok     = I_K_ACK & (outstanding_q != 5'd0);
    assign ack_spur   = I_K_ACK & (outstanding_q == 5'd0);
    assign m_valid    = (resp_cnt_q != '0);
    assign resp_wr    = ack_ok | ill_accept;
    assign resp_rd    = m_valid & I_M_READY;
    assign tmo_hit    = (tmo_q == TOW'(TIMEOUT_CYCLES));
    assign resp_rdata = resp_mem[resp_rd_q];

    assign resp_wdata = ack_ok
        ? {tag_mem[tag_rd_q], 1'b0, I_K_ENT_ERR, I_K_MULTI_HIT, I_K_SINGLE_HIT, I_K_KEY_VALUE}
        : {I_S_OP, 4'b1000, 32'd0};

    always_ff @(posedge I_CLK) begin
        if (k_accept) begin
            tag_mem[tag_wr_q] <= I_S_OP;
        end
        if (resp_wr) begin
            resp_mem[resp_wr_q] <= resp_wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        resp_wr_d     = resp_wr_q;
        resp_rd_d     = resp_rd_q;
        resp_cnt_d    = resp_cnt_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        k_valid_d     = 1'b0;
        k_search_d    = 1'b0;
        k_write_d     = 1'b0;
        k_erase_d     = 1'b0;
        k_update_d    = 1'b0;
        k_init_d      = 1'b0;
        k_key_d       = k_key_q;
        k_msk_d       = k_msk_q;
        k_pri_d       = k_pri_q;
        k_value_d     = k_value_q;

        if (k_accept) begin
            k_valid_d = 1'b1;
            k_key_d   = I_S_KEY;
            k_msk_d   = I_S_MSK;
            k_pri_d   = I_S_PRI;
            k_value_d = I_S_VALUE;
            case (I_S_OP)
                3'd0:    k_search_d = 1'b1;
                3'd1:    k_write_d  = 1'b1;
                3'd2:    k_erase_d  = 1'b1;
                3'd3:    k_update_d = 1'b1;
                default: k_valid_d  = 1'b1;
            endcase
            tag_wr_d = (tag_wr_q == TAW'(OUTSTANDING_MAX - 1)) ? '0 : tag_wr_q + TAW'(1);
        end
        if (ack_ok) begin
            tag_rd_d = (tag_rd_q == TAW'(OUTSTANDING_MAX - 1)) ? '0 : tag_rd_q + TAW'(1);
        end

        case ({k_accept, ack_ok})
            2'b10:   outstanding_d = outstanding_q + 5'd1;
            2'b01:   outstanding_d = outstanding_q - 5'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (resp_wr) begin
            resp_wr_d = resp_wr_q + RAW'(1);
        end
        if (resp_rd) begin
            resp_rd_d = resp_rd_q + RAW'(1);
        end
        case ({resp_wr, resp_rd})
            2'b10:   resp_cnt_d = resp_cnt_q + (RAW+1)'(1);
            2'b01:   resp_cnt_d = resp_cnt_q - (RAW+1)'(1);
            default: resp_cnt_d = resp_cnt_q;
        endcase

        if (ack_ok || (outstanding_q == 5'd0)) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + TOW'(1);
        end

        if (ack_spur) begin
            err_d[1] = 1'b1;
        end

        case (state_q)
            ST_INIT_WAIT:  if (I_K_READY) state_d = ST_RUN;
            ST_RUN:        if (accept && op_init) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (outstanding_q == 5'd0) begin
                    state_d  = ST_INIT_PULSE;
                    k_init_d = 1'b1;
                end
            end
            ST_INIT_PULSE: state_d = ST_INIT_WAIT;
            ST_ERROR:      state_d = ST_ERROR;
            default:       state_d = ST_INIT_WAIT;
        endcase

        // A hung kernel is terminal until reset; ACKs keep draining into the buffer.
        if (tmo_hit) begin
            state_d  = ST_ERROR;
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q       <= ST_INIT_WAIT;
            outstanding_q <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            resp_wr_q     <= '0;
            resp_rd_q     <= '0;
            resp_cnt_q    <= '0;
            tmo_q         <= '0;
            err_q         <= '0;
            k_valid_q     <= 1'b0;
            k_search_q    <= 1'b0;
            k_write_q     <= 1'b0;
            k_erase_q     <= 1'b0;
            k_update_q    <= 1'b0;
            k_init_q      <= 1'b0;
            k_key_q       <= '0;
            k_msk_q       <= '0;
            k_pri_q       <= '0;
            k_value_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            resp_wr_q     <= resp_wr_d;
            resp_rd_q     <= resp_rd_d;
            resp_cnt_q    <= resp_cnt_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            k_valid_q     <= k_valid_d;
            k_search_q    <= k_search_d;
            k_write_q     <= k_write_d;
            k_erase_q     <= k_erase_d;
            k_update_q    <= k_update_d;
            k_init_q      <= k_init_d;
            k_key_q       <= k_key_d;
            k_msk_q       <= k_msk_d;
            k_pri_q       <= k_pri_d;
            k_value_q     <= k_value_d;
        end
    end

    assign O_S_READY      = s_ready;
    assign O_K_CMD_INIT   = k_init_q;
    assign O_K_CMD_VALID  = k_valid_q;
    assign O_K_CMD_ERASE  = k_erase_q;
    assign O_K_CMD_WRITE  = k_write_q;
    assign O_K_CMD_SEARCH = k_search_q;
    assign O_K_CMD_UPDATE = k_update_q;
    assign O_K_CMD_READ   = 1'b0;
    assign O_K_KEY_DAT    = k_key_q;
    assign O_K_EKEY_MSK   = k_msk_q;
    assign O_K_KEY_PRI    = k_pri_q;
    assign O_K_KEY_VALUE  = k_value_q;
    assign O_M_VALID      = m_valid;
    assign O_M_OP         = m_valid ? resp_rdata[38:36] : 3'd0;
    assign O_M_STATUS     = m_valid ? resp_rdata[35:32] : 4'd0;
    assign O_M_VALUE      = m_valid ? resp_rdata[31:0] : 32'd0;
    assign O_OUTSTANDING  = outstanding_q;
    assign O_BUSY         = (state_q != ST_RUN);
    assign O_ERR          = err_q;

endmodule

// File: tb/tb_axonerve_kvs_cmd_issuer.sv
// tb/tb_axonerve_kvs_cmd_issuer.sv - directed vector bench for axonerve_kvs_cmd_issuer
module tb_axonerve_kvs_cmd_issuer;
    logic         I_CLK = 1'b0;
    logic         I_RST = 1'b1;
    logic         I_S_VALID = 1'b0;
    logic         O_S_READY;
    logic [2:0]   I_S_OP = 3'd0;
    logic [127:0] I_S_KEY = '0;
    logic [127:0] I_S_MSK = '0;
    logic [6:0]   I_S_PRI = '0;
    logic [31:0]  I_S_VALUE = '0;
    logic         I_K_READY = 1'b0;
    logic         I_K_WAIT = 1'b0;
    logic         I_K_CMD_FULL = 1'b0;
    logic         O_K_CMD_INIT, O_K_CMD_VALID, O_K_CMD_ERASE, O_K_CMD_WRITE;
    logic         O_K_CMD_SEARCH, O_K_CMD_UPDATE, O_K_CMD_READ;
    logic [127:0] O_K_KEY_DAT, O_K_EKEY_MSK;
    logic [6:0]   O_K_KEY_PRI;
    logic [31:0]  O_K_KEY_VALUE;
    logic         I_K_ACK = 1'b0;
    logic         I_K_ENT_ERR = 1'b0;
    logic         I_K_SINGLE_HIT = 1'b0;
    logic         I_K_MULTI_HIT = 1'b0;
    logic [31:0]  I_K_KEY_VALUE = '0;
    logic         O_M_VALID;
    logic         I_M_READY = 1'b0;
    logic [2:0]   O_M_OP;
    logic [3:0]   O_M_STATUS;
    logic [31:0]  O_M_VALUE;
    logic [4:0]   O_OUTSTANDING;
    logic         O_BUSY;
    logic [1:0]   O_ERR;

    axonerve_kvs_cmd_issuer dut (
        .I_CLK(I_CLK), .I_RST(I_RST),
        .I_S_VALID(I_S_VALID), .O_S_READY(O_S_READY), .I_S_OP(I_S_OP),
        .I_S_KEY(I_S_KEY), .I_S_MSK(I_S_MSK), .I_S_PRI(I_S_PRI), .I_S_VALUE(I_S_VALUE),
        .I_K_READY(I_K_READY), .I_K_WAIT(I_K_WAIT), .I_K_CMD_FULL(I_K_CMD_FULL),
        .O_K_CMD_INIT(O_K_CMD_INIT), .O_K_CMD_VALID(O_K_CMD_VALID),
        .O_K_CMD_ERASE(O_K_CMD_ERASE), .O_K_CMD_WRITE(O_K_CMD_WRITE),
        .O_K_CMD_SEARCH(O_K_CMD_SEARCH), .O_K_CMD_UPDATE(O_K_CMD_UPDATE),
        .O_K_CMD_READ(O_K_CMD_READ),
        .O_K_KEY_DAT(O_K_KEY_DAT), .O_K_EKEY_MSK(O_K_EKEY_MSK),
        .O_K_KEY_PRI(O_K_KEY_PRI), .O_K_KEY_VALUE(O_K_KEY_VALUE),
        .I_K_ACK(I_K_ACK), .I_K_ENT_ERR(I_K_ENT_ERR), .I_K_SINGLE_HIT(I_K_SINGLE_HIT),
        .I_K_MULTI_HIT(I_K_MULTI_HIT), .I_K_KEY_VALUE(I_K_KEY_VALUE),
        .O_M_VALID(O_M_VALID), .I_M_READY(I_M_READY), .O_M_OP(O_M_OP),
        .O_M_STATUS(O_M_STATUS), .O_M_VALUE(O_M_VALUE),
        .O_OUTSTANDING(O_OUTSTANDING), .O_BUSY(O_BUSY), .O_ERR(O_ERR)
    );

    always #5 I_CLK = ~I_CLK;

    logic [6:0] strobes;
    assign strobes = {O_K_CMD_VALID, O_K_CMD_SEARCH, O_K_CMD_WRITE, O_K_CMD_ERASE,
                      O_K_CMD_UPDATE, O_K_CMD_INIT, O_K_CMD_READ};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Kernel model: ACKs each issued command ack_delay cycles after its strobe.
    int          ack_delay = 3;
    logic        cfg_noack = 1'b0;
    logic        cfg_seq = 1'b0;
    logic        cfg_ent = 1'b0, cfg_multi = 1'b0, cfg_single = 1'b0;
    logic [31:0] cfg_val = '0;
    int          spur_req = 0;
    int          spur_done = 0;
    int          ack_seq = 0;
    int          cyc = 0;
    int          due_q[$];

    initial begin
        forever begin
            @(posedge I_CLK);
            #1;
            cyc++;
            if (O_K_CMD_VALID && !cfg_noack) due_q.push_back(cyc + ack_delay);
            I_K_ACK = 1'b0;
            I_K_ENT_ERR = 1'b0;
            I_K_MULTI_HIT = 1'b0;
            I_K_SINGLE_HIT = 1'b0;
            I_K_KEY_VALUE = '0;
            if ((due_q.size() > 0 && due_q[0] == cyc) || (spur_req != spur_done)) begin
                if (due_q.size() > 0 && due_q[0] == cyc) void'(due_q.pop_front());
                else spur_done++;
                I_K_ACK = 1'b1;
                I_K_ENT_ERR = cfg_ent;
                I_K_MULTI_HIT = cfg_multi;
                I_K_SINGLE_HIT = cfg_single;
                I_K_KEY_VALUE = cfg_seq ? cfg_val + 32'(ack_seq) : cfg_val;
                ack_seq++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cyc();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic do_reset();
        I_RST = 1'b1;
        repeat (3) next_cyc();
        I_RST = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [127:0] key, input logic [127:0] msk,
                        input logic [6:0] pri, input logic [31:0] val);
        bit ok = 1'b0;
        I_S_VALID = 1'b1;
        I_S_OP = op;
        I_S_KEY = key;
        I_S_MSK = msk;
        I_S_PRI = pri;
        I_S_VALUE = val;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge I_CLK);
            if (O_S_READY) ok = 1'b1;
            next_cyc();
        end
        I_S_VALID = 1'b0;
        if (!ok) bound_fail("send");
    endtask

    task automatic get_resp(output logic [2:0] op, output logic [3:0] st, output logic [31:0] v);
        bit ok = 1'b0;
        op = '0;
        st = '0;
        v = '0;
        I_M_READY = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge I_CLK);
            if (O_M_VALID) begin
                ok = 1'b1;
                op = O_M_OP;
                st = O_M_STATUS;
                v = O_M_VALUE;
            end
            next_cyc();
        end
        I_M_READY = 1'b0;
        if (!ok) bound_fail("get_resp");
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [127:0] key;
        logic [127:0] msk;
        logic [6:0]   pri;
        logic [31:0]  val;
        logic         a_ent;
        logic         a_multi;
        logic         a_single;
        logic [31:0]  a_val;
        logic [6:0]   exp_strb;
        logic [3:0]   exp_st;
        logic [31:0]  exp_v;
    } vec_t;

    vec_t vec[7];

    initial begin
        logic [2:0]  r_op;
        logic [3:0]  r_st;
        logic [31:0] r_v;
        int          accepted;
        int          base;
        int          elapsed;
        bit          seen;

        vec[0] = '{3'd0, 128'h0123456789abcdef_fedcba9876543210, 128'hffff0000, 7'h05, 32'h1,
                   1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 7'b1100000, 4'b0001, 32'hDEADBEEF};
        vec[1] = '{3'd1, 128'h55, 128'h0, 7'h7f, 32'hCAFE0001,
                   1'b0, 1'b0, 1'b0, 32'h11112222, 7'b1010000, 4'b0000, 32'h11112222};
        vec[2] = '{3'd2, 128'h66, 128'h3, 7'h10, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h0, 7'b1001000, 4'b0100, 32'h0};
        vec[3] = '{3'd3, 128'h77, 128'h0, 7'h01, 32'h12345678,
                   1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 7'b1000100, 4'b0011, 32'hA5A5A5A5};
        vec[4] = '{3'd5, 128'h88, 128'h0, 7'h00, 32'h9,
                   1'b0, 1'b0, 1'b0, 32'h0, 7'b0000000, 4'b1000, 32'h0};
        vec[5] = '{3'd7, 128'h99, 128'h0, 7'h00, 32'h9,
                   1'b0, 1'b0, 1'b0, 32'h0, 7'b0000000, 4'b1000, 32'h0};
        vec[6] = '{3'd0, 128'haa, 128'h1, 7'h22, 32'h0,
                   1'b0, 1'b1, 1'b0, 32'h00000042, 7'b1100000, 4'b0010, 32'h00000042};

        // Reset values, then INIT_WAIT holds while kernel not ready.
        repeat (3) next_cyc();
        @(negedge I_CLK);
        chk("rst_s_ready", O_S_READY, 0);
        chk("rst_busy", O_BUSY, 1);
        chk("rst_strobes", strobes, 0);
        chk("rst_m_valid", O_M_VALID, 0);
        chk("rst_outstanding", O_OUTSTANDING, 0);
        chk("rst_err", O_ERR, 0);
        chk("rst_key", O_K_KEY_DAT, 0);
        next_cyc();
        I_RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            @(negedge I_CLK);
            chk($sformatf("initwait%0d_ready", i), O_S_READY, 0);
            chk($sformatf("initwait%0d_busy", i), O_BUSY, 1);
        end
        next_cyc();
        I_K_READY = 1'b1;
        @(negedge I_CLK);
        chk("kready_same_cycle", O_S_READY, 0);
        next_cyc();
        @(negedge I_CLK);
        chk("kready_next_cycle", O_S_READY, 1);
        chk("run_busy", O_BUSY, 0);

        I_K_WAIT = 1'b1;
        #1 chk("gate_wait", O_S_READY, 0);
        I_K_WAIT = 1'b0;
        I_K_CMD_FULL = 1'b1;
        #1 chk("gate_full", O_S_READY, 0);
        I_K_CMD_FULL = 1'b0;
        #1 chk("gate_clear", O_S_READY, 1);
        next_cyc();

        for (int t = 0; t < 7; t++) begin
            cfg_ent = vec[t].a_ent;
            cfg_multi = vec[t].a_multi;
            cfg_single = vec[t].a_single;
            cfg_val = vec[t].a_val;
            send(vec[t].op, vec[t].key, vec[t].msk, vec[t].pri, vec[t].val);
            @(negedge I_CLK);
            chk($sformatf("vec%0d_strobe", t), strobes, vec[t].exp_strb);
            if (vec[t].exp_strb != 7'd0) begin
                chk($sformatf("vec%0d_key", t), O_K_KEY_DAT, vec[t].key);
                chk($sformatf("vec%0d_msk", t), O_K_EKEY_MSK, vec[t].msk);
                chk($sformatf("vec%0d_pri", t), O_K_KEY_PRI, vec[t].pri);
                chk($sformatf("vec%0d_val", t), O_K_KEY_VALUE, vec[t].val);
            end
            next_cyc();
            @(negedge I_CLK);
            chk($sformatf("vec%0d_strobe_off", t), strobes, 0);
            next_cyc();
            get_resp(r_op, r_st, r_v);
            chk($sformatf("vec%0d_resp_op", t), r_op, vec[t].op);
            chk($sformatf("vec%0d_resp_status", t), r_st, vec[t].exp_st);
            chk($sformatf("vec%0d_resp_value", t), r_v, vec[t].exp_v);
            @(negedge I_CLK);
            chk($sformatf("vec%0d_outstanding", t), O_OUTSTANDING, 0);
            chk($sformatf("vec%0d_drained", t), O_M_VALID, 0);
            next_cyc();
        end

        // Illegal op colliding with an ACK must wait one cycle.
        cfg_ent = 1'b0;
        cfg_multi = 1'b0;
        cfg_single = 1'b1;
        cfg_val = 32'h0BADF00D;
        send(3'd0, 128'h1, 128'h0, 7'h0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge I_CLK);
            if (I_K_ACK) seen = 1'b1;
            else next_cyc();
        end
        if (!seen) bound_fail("ill_wait_ack");
        I_S_VALID = 1'b1;
        I_S_OP = 3'd6;
        #1 chk("ill_blocked_by_ack", O_S_READY, 0);
        next_cyc();
        @(negedge I_CLK);
        chk("ill_after_ack_ready", O_S_READY, 1);
        next_cyc();
        I_S_VALID = 1'b0;
        @(negedge I_CLK);
        chk("ill_no_strobe", strobes, 0);
        next_cyc();
        get_resp(r_op, r_st, r_v);
        chk("ill_first_op", r_op, 3'd0);
        chk("ill_first_status", r_st, 4'b0001);
        chk("ill_first_value", r_v, 32'h0BADF00D);
        get_resp(r_op, r_st, r_v);
        chk("ill_second_op", r_op, 3'd6);
        chk("ill_second_status", r_st, 4'b1000);
        chk("ill_second_value", r_v, 32'h0);

        // Back-pressure: 20 searches offered, buffer depth caps acceptance at 16.
        cfg_seq = 1'b1;
        cfg_val = 32'hC0DE0000;
        base = ack_seq;
        accepted = 0;
        I_S_VALID = 1'b1;
        I_S_OP = 3'd0;
        for (int i = 0; i < 60; i++) begin
            @(negedge I_CLK);
            if (O_S_READY && I_S_VALID) accepted++;
            next_cyc();
            if (accepted >= 20) I_S_VALID = 1'b0;
        end
        @(negedge I_CLK);
        chk("bp_accepted", 32'(accepted), 32'd16);
        chk("bp_ready_low", O_S_READY, 0);
        chk("bp_outstanding", O_OUTSTANDING, 0);
        chk("bp_m_valid", O_M_VALID, 1);
        I_S_VALID = 1'b0;
        next_cyc();
        for (int i = 0; i < 16; i++) begin
            get_resp(r_op, r_st, r_v);
            chk($sformatf("bp%0d_op", i), r_op, 3'd0);
            chk($sformatf("bp%0d_status", i), r_st, 4'b0001);
            chk($sformatf("bp%0d_value", i), r_v, 32'hC0DE0000 + 32'(base + i));
        end
        @(negedge I_CLK);
        chk("bp_empty", O_M_VALID, 0);
        chk("bp_ready_back", O_S_READY, 1);
        next_cyc();

        // INIT waits for both ACKs, pulses once, then waits for kernel ready.
        cfg_seq = 1'b0;
        cfg_single = 1'b0;
        cfg_val = 32'h0;
        ack_delay = 5;
        base = ack_seq;
        send(3'd1, 128'h10, 128'h0, 7'h0, 32'h1);
        send(3'd2, 128'h20, 128'h0, 7'h0, 32'h0);
        send(3'd4, 128'h0, 128'h0, 7'h0, 32'h0);
        @(negedge I_CLK);
        chk("drain_ready", O_S_READY, 0);
        chk("drain_busy", O_BUSY, 1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge I_CLK);
            if (O_K_CMD_INIT) begin
                seen = 1'b1;
                chk("init_acks_before", 32'(ack_seq - base), 32'd2);
                chk("init_outstanding", O_OUTSTANDING, 0);
                chk("init_no_valid", O_K_CMD_VALID, 0);
                I_K_READY = 1'b0;
            end
            next_cyc();
        end
        if (!seen) bound_fail("init_pulse");
        @(negedge I_CLK);
        chk("init_one_cycle", O_K_CMD_INIT, 0);
        chk("init_wait_busy", O_BUSY, 1);
        repeat (3) next_cyc();
        @(negedge I_CLK);
        chk("init_wait_ready", O_S_READY, 0);
        next_cyc();
        I_K_READY = 1'b1;
        next_cyc();
        @(negedge I_CLK);
        chk("init_run_busy", O_BUSY, 0);
        chk("init_run_ready", O_S_READY, 1);
        next_cyc();
        get_resp(r_op, r_st, r_v);
        chk("init_resp0_op", r_op, 3'd1);
        get_resp(r_op, r_st, r_v);
        chk("init_resp1_op", r_op, 3'd2);
        @(negedge I_CLK);
        chk("init_no_resp", O_M_VALID, 0);
        next_cyc();
        ack_delay = 3;

        // Timeout: search never ACKed.
        do_reset();
        cfg_noack = 1'b1;
        send(3'd0, 128'h5, 128'h0, 7'h0, 32'h0);
        elapsed = 0;
        seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge I_CLK);
            if (O_ERR != 2'b00) seen = 1'b1;
            else begin
                elapsed++;
                next_cyc();
            end
        end
        if (!seen) bound_fail("timeout_wait");
        chk("timeout_err", O_ERR, 2'b01);
        chk("timeout_not_early", elapsed >= 1000, 1);
        next_cyc();
        I_S_VALID = 1'b1;
        I_S_OP = 3'd0;
        repeat (4) next_cyc();
        @(negedge I_CLK);
        chk("error_ready", O_S_READY, 0);
        chk("error_busy", O_BUSY, 1);
        next_cyc();
        I_S_VALID = 1'b0;
        cfg_single = 1'b1;
        cfg_val = 32'h77;
        spur_req++;
        repeat (2) next_cyc();
        @(negedge I_CLK);
        chk("error_ack_outstanding", O_OUTSTANDING, 0);
        chk("error_ack_err", O_ERR, 2'b01);
        next_cyc();
        get_resp(r_op, r_st, r_v);
        chk("error_ack_value", r_v, 32'h77);
        @(negedge I_CLK);
        chk("error_stuck_ready", O_S_READY, 0);
        next_cyc();
        do_reset();
        cfg_noack = 1'b0;
        @(negedge I_CLK);
        chk("post_rst_err", O_ERR, 0);
        chk("post_rst_outstanding", O_OUTSTANDING, 0);
        next_cyc();

        // Spurious ACK with nothing outstanding.
        next_cyc();
        spur_req++;
        repeat (3) next_cyc();
        @(negedge I_CLK);
        chk("spur_err", O_ERR, 2'b10);
        chk("spur_no_resp", O_M_VALID, 0);
        chk("spur_outstanding", O_OUTSTANDING, 0);
        chk("spur_ready", O_S_READY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
